isa_io_cycle: RTL
=================

Name: isa_io_cycle

Overview:
- Downstream of the port-scan sequencer: converts single request/response transactions into correctly timed ISA I/O read/write cycles on the CT2960 bus.
- Drives address, data-out with output enable, IOR#, IOW# and AEN; captures read data.
- Replaces direct data_dir-to-IOR/IOW strobing in the riser top level. Runs on the 50 MHz system clock; all bus timing is counted in system clocks.

Parameters:
- SETUP_CYC, 5, address/AEN/write-data setup before strobe, in clocks (100 ns). Legal range 1..255.
- STROBE_CYC, 25, IOR#/IOW# active width, in clocks (500 ns). Legal range 1..255.
- HOLD_CYC, 3, address/data hold after strobe deassert, in clocks. Legal range 1..255.
- RECOVERY_CYC, 10, idle gap before the next request is accepted, in clocks. Legal range 1..255.

Ports:
- sys_clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = I/O write, 0 = I/O read
- req_addr  in  16  I/O port address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-clock pulse: cycle complete
- rsp_rdata  out  16  captured read data
- isa_data_in  in  16  bus data from pads
- isa_data_out  out  16  bus data to pads
- isa_data_oe  out  1  1 = drive D[15:0]
- isa_addr  out  16  bus address
- isa_ior_n  out  1  I/O read strobe, active low
- isa_iow_n  out  1  I/O write strobe, active low
- isa_aen  out  1  address enable (low = CPU I/O cycle valid)
- isa_iochrdy  in  1  channel ready (used only with IOCHRDY_EN)

Behaviour:
- Reset values (asynchronous, while reset_n = 0):
  - state = IDLE; req_ready = 1; rsp_valid = 0.
  - rsp_rdata, isa_addr, isa_data_out = 0; isa_data_oe = 0.
  - isa_ior_n = 1, isa_iow_n = 1, isa_aen = 1.
  - Reset mid-cycle aborts immediately: strobes deassert, data_oe drops, and no rsp_valid is issued.
- All outputs are registered; no combinational path from any input to any output.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on the clock where req_valid && req_ready. req_write, req_addr and req_wdata are latched on that edge.
  - req_* inputs are ignored at all other times.
- Single 8-bit down-counter, loaded with (param − 1) on entry to each timed state; the state exits when the count is 0.
- States:
  - IDLE: aen = 1, strobes high, oe = 0. On accept → SETUP.
  - SETUP (SETUP_CYC clocks): isa_addr = latched addr, aen = 0. For a write, oe = 1 and data_out = latched wdata. → STROBE.
  - STROBE (STROBE_CYC clocks): ior_n = 0 for a read, iow_n = 0 for a write. On the final STROBE clock, isa_data_in is registered into rsp_rdata (reads only; writes leave rsp_rdata unchanged). → HOLD.
  - HOLD (HOLD_CYC clocks): strobes high; addr, aen = 0 and write data/oe are retained. rsp_valid pulses on the first HOLD clock. → RECOVER.
  - RECOVER (RECOVERY_CYC clocks): aen = 1, oe = 0, addr retained. → IDLE.
- Strobe and oe timing:
  - ior_n and iow_n are never low simultaneously.
  - oe is never 1 during a read cycle.
- Throughput: accept-to-accept minimum = 1 + SETUP + STROBE + HOLD + RECOVERY clocks (44 at defaults).
- Back-to-back: req_valid held high is accepted on the first IDLE clock after RECOVER.

Optional Feature:
- Macro: ISA_IOCHRDY_EN.
- With the macro defined:
  - isa_iochrdy passes through a 2-flop synchronizer.
  - If the synchronized value is 0 when the STROBE count reaches 0, STROBE is extended, clock by clock, until it reads 1. Read data is captured on the clock the extension ends.
  - A separate 10-bit wait counter bounds the extension to 781 clocks (~15.6 µs). On timeout, STROBE ends normally and rdata is 16'hFFFF for reads.
- Without the macro: isa_iochrdy is unused, and STROBE is exactly STROBE_CYC clocks.

Test Plan:
- Reset: hold reset_n = 0, then release → req_ready = 1, ior_n = iow_n = aen = 1, oe = 0. Assert reset_n = 0 mid-STROBE → iow_n returns to 1 and oe returns to 0 asynchronously, with no rsp_valid.
- Write addr 16'h0220, data 16'h00A5 → aen low and oe high 5 clocks before iow_n falls; iow_n low exactly 25 clocks; data held 3 clocks after iow_n rises; rsp_valid pulses once.
- Read addr 16'h022A with bus driving 16'h00AA → ior_n low 25 clocks; oe stays 0 throughout; rsp_rdata = 16'h00AA on the rsp_valid pulse.
- Back-to-back write then read with req_valid held high → second accept exactly 44 clocks after the first; ior_n/iow_n never overlap.
- With ISA_IOCHRDY_EN: hold iochrdy = 0 for 40 clocks from strobe start → ior_n low for ~40 + sync latency clocks. Hold iochrdy = 0 permanently → strobe ends after the timeout and rsp_rdata = 16'hFFFF.

Source files
------------

// File: rtl/isa_io_cycle.sv
// rtl/isa_io_cycle.sv - ISA I/O read/write cycle generator; optional IOCHRDY wait states under ISA_IOCHRDY_EN
module isa_io_cycle #(
    parameter int SETUP_CYC    = 5,
    parameter int STROBE_CYC   = 25,
    parameter int HOLD_CYC     = 3,
    parameter int RECOVERY_CYC = 10
) (
    input  logic        sys_clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic [15:0] isa_data_in,
    output logic [15:0] isa_data_out,
    output logic        isa_data_oe,
    output logic [15:0] isa_addr,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    output logic        isa_aen,
    input  logic        isa_iochrdy
);

    localparam logic [7:0] SETUP_LD    = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD   = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD     = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVERY_LD = 8'(RECOVERY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       lat_write;
    logic       accept, go_strobe, strobe_end, go_recover;
    logic       strobe_release;
    logic       timed_out;

`ifdef ISA_IOCHRDY_EN
    localparam logic [9:0] WAIT_MAX = 10'd781;

    logic [1:0] rdy_sync;
    logic [9:0] wait_cnt;

    // Bring the asynchronous channel-ready line into the clock domain
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) rdy_sync <= 2'b00;
        else          rdy_sync <= {rdy_sync[0], isa_iochrdy};
    end

    // Count wait-state clocks once the nominal strobe width has elapsed
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n)                                       wait_cnt <= '0;
        else if (state != ST_STROBE)                        wait_cnt <= '0;
        else if (cnt == 8'd0 && !strobe_release)            wait_cnt <= wait_cnt + 10'd1;
    end

    assign strobe_release = rdy_sync[1] || (wait_cnt == WAIT_MAX);
    assign timed_out      = !rdy_sync[1];
`else
    logic unused_iochrdy;
    assign unused_iochrdy = isa_iochrdy;
    assign strobe_release = 1'b1;
    assign timed_out      = 1'b0;
`endif

    // State and phase counter register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: each timed state runs until its down-counter hits zero
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        go_strobe  = 1'b0;
        strobe_end = 1'b0;
        go_recover = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    go_strobe = 1'b1;
                    state_nxt = ST_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (strobe_release) begin
                    strobe_end = 1'b1;
                    state_nxt  = ST_HOLD;
                    cnt_nxt    = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    go_recover = 1'b1;
                    state_nxt  = ST_RECOVER;
                    cnt_nxt    = RECOVERY_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt == 8'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered bus and response outputs, updated on phase transitions
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            isa_addr     <= '0;
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
            isa_ior_n    <= 1'b1;
            isa_iow_n    <= 1'b1;
            isa_aen      <= 1'b1;
            lat_write    <= 1'b0;
        end else begin
            req_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= strobe_end;
            if (accept) begin
                lat_write <= req_write;
                isa_addr  <= req_addr;
                isa_aen   <= 1'b0;
                if (req_write) begin
                    isa_data_out <= req_wdata;
                    isa_data_oe  <= 1'b1;
                end
            end
            if (go_strobe) begin
                isa_ior_n <= lat_write;
                isa_iow_n <= !lat_write;
            end
            if (strobe_end) begin
                isa_ior_n <= 1'b1;
                isa_iow_n <= 1'b1;
                if (!lat_write) rsp_rdata <= timed_out ? 16'hFFFF : isa_data_in;
            end
            if (go_recover) begin
                isa_aen     <= 1'b1;
                isa_data_oe <= 1'b0;
            end
        end
    end

endmodule
